fetch_unit: RTL and testbench

- Instruction-fetch stage of the RISC-V core: owns the PC, issues one instruction-memory request at a time, and hands the fetched instruction to decode through a valid/ready handshake.
- Closes the loop from execute: it consumes the ALU's branch flag and ALU_result (JALR target), plus the execute-computed PC+imm target, to compute the next PC.
- Redirects flush any in-flight or held fetch.

---
 rtl/rv_pkg.sv | 23 ++
 rtl/next_pc_logic.sv | 35 +++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the RISC-V front end: next-PC select codes, the NOP word
// and the fetch FSM state codes.
package rv_pkg;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JAL    = 2'd2;
  localparam logic [1:0] PC_SEL_JALR   = 2'd3;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  localparam logic [1:0] FETCH_REQ  = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_HOLD = 2'd2;

  // Only a taken conditional branch or an unconditional jump moves the PC.
  function automatic logic redirect_taken(input logic valid, input logic [1:0] sel,
                                          input logic br);
    return valid & (((sel == PC_SEL_BRANCH) & br) | (sel == PC_SEL_JAL) |
                    (sel == PC_SEL_JALR));
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational redirect decode: taken detection, target select, word alignment
// and detection of a target that was only half-word aligned.
module next_pc_logic
  import rv_pkg::*;
#(
  parameter int ADDRESS_BITS = 32
) (
  input  logic                    i_redirect_valid,
  input  logic [1:0]              i_next_pc_select,
  input  logic                    i_branch,
  input  logic [ADDRESS_BITS-1:0] i_target_pc,
  input  logic [ADDRESS_BITS-1:0] i_alu_result,
  output logic                    o_taken,
  output logic [ADDRESS_BITS-1:0] o_new_pc,
  output logic                    o_misaligned
);

  localparam logic [ADDRESS_BITS-1:0] BIT0_MASK = {{(ADDRESS_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDRESS_BITS-1:0] WORD_MASK = {{(ADDRESS_BITS-2){1'b0}}, 2'b11};

  logic [ADDRESS_BITS-1:0] w_raw_target;

  // JALR clears bit 0 before alignment; bit 1 surviving that means misaligned.
  always_comb begin
    w_raw_target = i_target_pc;
    if (i_next_pc_select == PC_SEL_JALR) begin
      w_raw_target = i_alu_result & ~BIT0_MASK;
    end
  end

  assign o_taken      = redirect_taken(i_redirect_valid, i_next_pc_select, i_branch);
  assign o_new_pc     = w_raw_target & ~WORD_MASK;
  assign o_misaligned = o_taken & w_raw_target[1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight at a
// time and presents the fetched word to decode with a valid/ready handshake.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ADDRESS_BITS = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDRESS_BITS-1:0] imem_req_addr,
  input  logic                    imem_resp_valid,
  input  logic [31:0]             imem_resp_data,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [31:0]             instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  input  logic                    redirect_valid,
  input  logic [1:0]              next_PC_select,
  input  logic                    branch,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic [ADDRESS_BITS-1:0] ALU_result,
  output logic                    misaligned
);

  localparam logic [ADDRESS_BITS-1:0] RESET_ADDR = RESET_PC[ADDRESS_BITS-1:0];

  logic [1:0]              r_state;
  logic [ADDRESS_BITS-1:0] r_pc;
  logic [31:0]             r_instruction;
  logic [ADDRESS_BITS-1:0] r_inst_pc;
  logic                    r_misaligned;
  logic                    r_drop;

  logic                    w_taken;
  logic [ADDRESS_BITS-1:0] w_new_pc;
  logic                    w_target_misaligned;

  next_pc_logic #(
    .ADDRESS_BITS(ADDRESS_BITS)
  ) u_next_pc (
    .i_redirect_valid(redirect_valid),
    .i_next_pc_select(next_PC_select),
    .i_branch        (branch),
    .i_target_pc     (target_PC),
    .i_alu_result    (ALU_result),
    .o_taken         (w_taken),
    .o_new_pc        (w_new_pc),
    .o_misaligned    (w_target_misaligned)
  );

  assign imem_req_valid = (r_state == FETCH_REQ) & ~reset;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_state == FETCH_HOLD);
  assign instruction    = r_instruction;
  assign inst_PC        = r_inst_pc;
  assign misaligned     = r_misaligned;

  // A redirect always wins: it retargets the PC and either flushes the held word
  // or marks the in-flight response for discard via r_drop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= FETCH_REQ;
      r_pc          <= RESET_ADDR;
      r_instruction <= NOP_INSTRUCTION;
      r_inst_pc     <= RESET_ADDR;
      r_misaligned  <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      if (w_target_misaligned) begin
        r_misaligned <= 1'b1;
      end
      case (r_state)
        FETCH_REQ: begin
          if (w_taken) begin
            r_pc <= w_new_pc;
          end
          if (imem_req_ready) begin
            r_state <= FETCH_WAIT;
            if (w_taken) begin
              r_drop <= 1'b1;
            end
          end
        end
        FETCH_WAIT: begin
          if (w_taken) begin
            r_pc <= w_new_pc;
            if (imem_resp_valid) begin
              r_drop  <= 1'b0;
              r_state <= FETCH_REQ;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= FETCH_REQ;
            end else begin
              r_instruction <= imem_resp_data;
              r_inst_pc     <= r_pc;
              r_state       <= FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (w_taken) begin
            r_pc    <= w_new_pc;
            r_state <= FETCH_REQ;
          end else if (inst_ready) begin
            r_pc    <= r_pc + ADDRESS_BITS'(4);
            r_state <= FETCH_REQ;
          end
        end
        default: r_state <= FETCH_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory model, a PC-level
// reference model checked every cycle, and hand-computed spot checks.
module tb_fetch_unit;

  localparam logic [31:0] PATTERN = 32'hA5A5_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_PC;
  logic        redirect_valid;
  logic [1:0]  next_PC_select;
  logic        branch;
  logic [31:0] target_PC;
  logic [31:0] ALU_result;
  logic        misaligned;

  int checks = 0;
  int errors = 0;
  int memLat = 1;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .ADDRESS_BITS(32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_PC        (inst_PC),
    .redirect_valid (redirect_valid),
    .next_PC_select (next_PC_select),
    .branch         (branch),
    .target_PC      (target_PC),
    .ALU_result     (ALU_result),
    .misaligned     (misaligned)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [1:0] sel, input logic br,
                               input logic [31:0] tgt, input logic [31:0] alu);
    redirect_valid = rv;
    next_PC_select = sel;
    branch         = br;
    target_PC      = tgt;
    ALU_result     = alu;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic waitHold(input string name, input logic [31:0] expPc);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (inst_valid) found = 1'b1;
    end
    if (!found) begin
      checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({name, "_pc"}, inst_PC, expPc);
      checkOutput({name, "_instr"}, instruction, expPc ^ PATTERN);
    end
  endtask

  // Memory: accepts while ready, answers memLat cycles later with addr ^ PATTERN.
  initial begin
    int cnt = 0;
    logic [31:0] paddr = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) begin
        cnt   = memLat;
        paddr = imem_req_addr;
      end
      @(posedge clock);
      #1;
      imem_resp_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = paddr ^ PATTERN;
        end
      end
    end
  end

  // Architectural PC model: reset, consumed instruction, or taken redirect.
  initial begin
    logic [31:0] mPc  = 32'h0;
    logic        mMis = 1'b0;
    logic [31:0] raw;
    bit          taken;
    int          outstanding = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        checkOutput("cmp_reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
        mPc  = 32'h0;
        mMis = 1'b0;
        outstanding = 0;
      end else begin
        checkOutput("cmp_misaligned", {31'd0, misaligned}, {31'd0, mMis});
        if (inst_valid) begin
          checkOutput("cmp_inst_pc", inst_PC, mPc);
          checkOutput("cmp_instruction", instruction, mPc ^ PATTERN);
        end
        if (imem_req_valid) begin
          checkOutput("cmp_req_addr", imem_req_addr, mPc);
          checkOutput("cmp_req_and_valid", {31'd0, inst_valid}, 32'd0);
        end
        if (imem_resp_valid && outstanding > 0) outstanding--;
        if (imem_req_valid && imem_req_ready) begin
          checkOutput("cmp_one_outstanding", outstanding, 0);
          outstanding++;
        end
        taken = redirect_valid && ((next_PC_select == 2'd1 && branch) ||
                                   next_PC_select == 2'd2 || next_PC_select == 2'd3);
        if (taken) begin
          raw  = (next_PC_select == 2'd3) ? {ALU_result[31:1], 1'b0} : target_PC;
          mMis = mMis | raw[1];
          mPc  = {raw[31:2], 2'b00};
        end else if (inst_valid && inst_ready) begin
          mPc = mPc + 32'd4;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    checkOutput("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
    nextCycle();
    nextCycle();
    reset = 1'b0;

    $display("[TB] sequential fetch");
    @(negedge clock);
    checkOutput("post_reset_inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("post_reset_instruction", instruction, NOP);
    checkOutput("post_reset_inst_pc", inst_PC, 32'h0);
    checkOutput("post_reset_misaligned", {31'd0, misaligned}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      checkOutput("seq_req_valid", {31'd0, imem_req_valid}, 32'd1);
      checkOutput("seq_req_addr", imem_req_addr, 32'(k * 4));
      @(negedge clock);
      checkOutput("seq_wait_inst_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge clock);
      checkOutput("seq_hold_inst_valid", {31'd0, inst_valid}, 32'd1);
      checkOutput("seq_hold_pc", inst_PC, 32'(k * 4));
      checkOutput("seq_hold_instr", instruction, PATTERN | 32'(k * 4));
    end

    $display("[TB] decode stall");
    nextCycle();
    inst_ready = 1'b0;
    waitHold("stall_first", 32'h0000_000C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
      checkOutput("stall_inst_pc", inst_PC, 32'h0000_000C);
      checkOutput("stall_instr", instruction, 32'hA5A5_000C);
      checkOutput("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    nextCycle();
    inst_ready = 1'b1;
    @(negedge clock);
    checkOutput("stall_ready_cycle_valid", {31'd0, inst_valid}, 32'd1);
    nextCycle();
    inst_ready = 1'b0;
    @(negedge clock);
    checkOutput("stall_next_req_addr", imem_req_addr, 32'h0000_0010);

    $display("[TB] taken branch in HOLD");
    waitHold("hold_0x10", 32'h0000_0010);
    nextCycle();
    applyStimulus(1'b1, 2'd1, 1'b1, 32'h0000_0040, 32'h0);
    inst_ready = 1'b1;
    @(negedge clock);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    checkOutput("branch_flush_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("branch_req_addr", imem_req_addr, 32'h0000_0040);
    waitHold("branch_target", 32'h0000_0040);

    $display("[TB] untaken branch");
    nextCycle();
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h0000_0080, 32'h0);
    @(negedge clock);
    checkOutput("untaken_req_addr", imem_req_addr, 32'h0000_0044);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    waitHold("untaken_seq", 32'h0000_0044);

    $display("[TB] JAL with request accept, then JAL in WAIT");
    nextCycle();
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'h0);
    @(negedge clock);
    checkOutput("jal_req_old_addr", imem_req_addr, 32'h0000_0048);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    memLat = 2;
    @(negedge clock);
    checkOutput("jal_drop_valid", {31'd0, inst_valid}, 32'd0);
    nextCycle();
    @(negedge clock);
    checkOutput("jal_req_addr_8", imem_req_addr, 32'h0000_0008);
    nextCycle();
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
    @(negedge clock);
    checkOutput("wait_redirect_no_req", {31'd0, imem_req_valid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    memLat = 1;
    @(negedge clock);
    checkOutput("wait_stale_dropped", {31'd0, inst_valid}, 32'd0);
    nextCycle();
    @(negedge clock);
    checkOutput("wait_req_addr_100", imem_req_addr, 32'h0000_0100);
    waitHold("wait_target", 32'h0000_0100);

    $display("[TB] JALR misaligned, coincident with response");
    nextCycle();
    @(negedge clock);
    checkOutput("jalr_req_addr", imem_req_addr, 32'h0000_0104);
    nextCycle();
    applyStimulus(1'b1, 2'd3, 1'b0, 32'h0, 32'h0000_0203);
    @(negedge clock);
    checkOutput("jalr_pre_misaligned", {31'd0, misaligned}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    checkOutput("jalr_req_addr_200", imem_req_addr, 32'h0000_0200);
    checkOutput("jalr_misaligned", {31'd0, misaligned}, 32'd1);
    waitHold("jalr_target", 32'h0000_0200);
    checkOutput("jalr_misaligned_sticky", {31'd0, misaligned}, 32'd1);

    $display("[TB] reset during WAIT");
    nextCycle();
    memLat = 2;
    @(negedge clock);
    nextCycle();
    reset  = 1'b1;
    memLat = 1;
    @(negedge clock);
    nextCycle();
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_wait_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("rst_wait_req_addr", imem_req_addr, 32'h0);
    checkOutput("rst_wait_inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("rst_wait_misaligned", {31'd0, misaligned}, 32'd0);
    checkOutput("rst_wait_instruction", instruction, NOP);
    waitHold("rst_refetch", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
